// File: rtl/sram_like_arbiter.sv
// Two-master arbiter in front of a single sram-like slave port: one transaction in flight,
// grant locked from issue until addr_ok, completion routed back to the owning master.
module sram_like_arbiter #(
    parameter int PRIO_DATA = 1,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                inst_req,
    input  logic                inst_wr,
    input  logic [1:0]          inst_size,
    input  logic [ADDR_W-1:0]   inst_addr,
    input  logic [DATA_W/8-1:0] inst_wstrb,
    input  logic [DATA_W-1:0]   inst_wdata,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,

    input  logic                data_req,
    input  logic                data_wr,
    input  logic [1:0]          data_size,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,

    output logic                req,
    output logic                wr,
    output logic [1:0]          size,
    output logic [ADDR_W-1:0]   addr,
    output logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   wdata,
    input  logic                addr_ok,
    input  logic                data_ok,
    input  logic [DATA_W-1:0]   rdata,

    output logic                proto_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    state_t state;
    state_t state_nxt;
    logic   owner;
    logic   owner_nxt;
    logic   last_grant;
    logic   last_grant_nxt;
    logic   proto_err_nxt;
    logic   winner;

    // Conflict resolution: fixed data priority, or alternate away from the last grant.
    always_comb begin
        winner = OWN_INST;
        if (inst_req && data_req) begin
            winner = (PRIO_DATA != 0) ? OWN_DATA : ~last_grant;
        end else if (data_req) begin
            winner = OWN_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= OWN_INST;
            last_grant <= OWN_INST;
            proto_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_grant <= last_grant_nxt;
            proto_err  <= proto_err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_grant_nxt = last_grant;
        // A completion is only legal while a transaction is outstanding.
        proto_err_nxt  = proto_err | (data_ok && (state != WAIT));
        case (state)
            IDLE: begin
                if (inst_req || data_req) begin
                    owner_nxt = winner;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (addr_ok) begin
                    last_grant_nxt = owner;
                    state_nxt      = WAIT;
                end
            end
            WAIT: begin
                if (data_ok) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshakes are masked during reset so nothing leaks before the state register clears.
    always_comb begin
        req          = 1'b0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        wr           = (owner == OWN_DATA) ? data_wr    : inst_wr;
        size         = (owner == OWN_DATA) ? data_size  : inst_size;
        addr         = (owner == OWN_DATA) ? data_addr  : inst_addr;
        wstrb        = (owner == OWN_DATA) ? data_wstrb : inst_wstrb;
        wdata        = (owner == OWN_DATA) ? data_wdata : inst_wdata;
        inst_rdata   = rdata;
        data_rdata   = rdata;
        if (!reset) begin
            case (state)
                REQ: begin
                    req          = 1'b1;
                    inst_addr_ok = addr_ok && (owner == OWN_INST);
                    data_addr_ok = addr_ok && (owner == OWN_DATA);
                end
                WAIT: begin
                    inst_data_ok = data_ok && (owner == OWN_INST);
                    data_data_ok = data_ok && (owner == OWN_DATA);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: a fixed-priority and a round-robin instance share stimulus
// and are both compared every cycle against a transaction-level reference model.
module tb_sram_like_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic [3:0]  inst_wstrb, data_wstrb;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;

    // Index 0: PRIO_DATA=1, index 1: PRIO_DATA=0.
    logic        s_inst_addr_ok[2], s_inst_data_ok[2], s_data_addr_ok[2], s_data_data_ok[2];
    logic        s_req[2], s_wr[2], s_proto_err[2];
    logic [1:0]  s_size[2];
    logic [31:0] s_addr[2], s_wdata[2], s_inst_rdata[2], s_data_rdata[2];
    logic [3:0]  s_wstrb[2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sram_like_arbiter #(.PRIO_DATA(1), .ADDR_W(32), .DATA_W(32)) dut_prio (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(s_inst_addr_ok[0]),
        .inst_data_ok(s_inst_data_ok[0]), .inst_rdata(s_inst_rdata[0]),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(s_data_addr_ok[0]),
        .data_data_ok(s_data_data_ok[0]), .data_rdata(s_data_rdata[0]),
        .req(s_req[0]), .wr(s_wr[0]), .size(s_size[0]), .addr(s_addr[0]), .wstrb(s_wstrb[0]),
        .wdata(s_wdata[0]), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .proto_err(s_proto_err[0])
    );

    sram_like_arbiter #(.PRIO_DATA(0), .ADDR_W(32), .DATA_W(32)) dut_rr (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(s_inst_addr_ok[1]),
        .inst_data_ok(s_inst_data_ok[1]), .inst_rdata(s_inst_rdata[1]),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(s_data_addr_ok[1]),
        .data_data_ok(s_data_data_ok[1]), .data_rdata(s_data_rdata[1]),
        .req(s_req[1]), .wr(s_wr[1]), .size(s_size[1]), .addr(s_addr[1]), .wstrb(s_wstrb[1]),
        .wdata(s_wdata[1]), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .proto_err(s_proto_err[1])
    );

    // Reference model: a transaction is either being offered to the slave, or outstanding.
    bit m_issuing = 1'b0;
    bit m_outstanding = 1'b0;
    bit m_err = 1'b0;
    bit m_own[2];
    bit log0[$];
    bit log1[$];

    function automatic bit last_grant_of(int k);
        if (k == 0) return (log0.size() == 0) ? 1'b0 : log0[$];
        return (log1.size() == 0) ? 1'b0 : log1[$];
    endfunction

    // 1 = data master wins.
    function automatic bit pick(int k);
        if (inst_req && data_req) return (k == 0) ? 1'b1 : !last_grant_of(k);
        return data_req;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_cmp();
        bit live, o, e_req;
        live = !reset;
        for (int k = 0; k < 2; k++) begin
            o = m_own[k];
            e_req = live && m_issuing;
            chk($sformatf("req[%0d]", k), 32'(s_req[k]), 32'(e_req));
            chk($sformatf("inst_addr_ok[%0d]", k), 32'(s_inst_addr_ok[k]), 32'(e_req && !o && addr_ok));
            chk($sformatf("data_addr_ok[%0d]", k), 32'(s_data_addr_ok[k]), 32'(e_req && o && addr_ok));
            chk($sformatf("inst_data_ok[%0d]", k), 32'(s_inst_data_ok[k]),
                32'(live && m_outstanding && !o && data_ok));
            chk($sformatf("data_data_ok[%0d]", k), 32'(s_data_data_ok[k]),
                32'(live && m_outstanding && o && data_ok));
            chk($sformatf("inst_rdata[%0d]", k), s_inst_rdata[k], rdata);
            chk($sformatf("data_rdata[%0d]", k), s_data_rdata[k], rdata);
            chk($sformatf("proto_err[%0d]", k), 32'(s_proto_err[k]), 32'(m_err));
            if (e_req) begin
                chk($sformatf("addr[%0d]", k), s_addr[k], o ? data_addr : inst_addr);
                chk($sformatf("wr[%0d]", k), 32'(s_wr[k]), 32'(o ? data_wr : inst_wr));
                chk($sformatf("size[%0d]", k), 32'(s_size[k]), 32'(o ? data_size : inst_size));
                chk($sformatf("wstrb[%0d]", k), 32'(s_wstrb[k]), 32'(o ? data_wstrb : inst_wstrb));
                chk($sformatf("wdata[%0d]", k), s_wdata[k], o ? data_wdata : inst_wdata);
            end
        end
    endtask

    task automatic model_tick();
        if (reset) begin
            m_issuing = 1'b0;
            m_outstanding = 1'b0;
            m_err = 1'b0;
            log0.delete();
            log1.delete();
        end else begin
            if (data_ok && !m_outstanding) m_err = 1'b1;
            if (m_outstanding) begin
                if (data_ok) m_outstanding = 1'b0;
            end else if (m_issuing) begin
                if (addr_ok) begin
                    m_issuing = 1'b0;
                    m_outstanding = 1'b1;
                    log0.push_back(m_own[0]);
                    log1.push_back(m_own[1]);
                end
            end else if (inst_req || data_req) begin
                m_own[0] = pick(0);
                m_own[1] = pick(1);
                m_issuing = 1'b1;
            end
        end
    endtask

    task automatic drive(input bit ireq, input bit dreq, input bit aok, input bit dok);
        inst_req = ireq;
        data_req = dreq;
        addr_ok  = aok;
        data_ok  = dok;
    endtask

    task automatic begin_cycle();
        @(negedge clk);
        model_cmp();
    endtask

    task automatic end_cycle();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic step(input bit ireq, input bit dreq, input bit aok, input bit dok);
        drive(ireq, dreq, aok, dok);
        begin_cycle();
        end_cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    typedef struct {
        bit          ireq, dreq, aok, dok;
        logic [31:0] rd;
        bit          e_req, e_iaok, e_daok, e_idok, e_ddok, e_perr;
    } vec_t;

    vec_t vecs[11];
    bit   obs;

    initial begin
        // Inst read, stray data_ok in IDLE, then a data read with proto_err already set.
        vecs[0]  = '{1, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 0, 0, 0, 32'h0,        1, 0, 0, 0, 0, 0};
        vecs[2]  = '{1, 0, 1, 0, 32'h0,        1, 1, 0, 0, 0, 0};
        vecs[3]  = '{0, 0, 0, 1, 32'h3C1DBFC0, 0, 0, 0, 1, 0, 0};
        vecs[4]  = '{0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0};
        vecs[5]  = '{0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0};
        vecs[6]  = '{0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 1};
        vecs[7]  = '{0, 1, 0, 0, 32'h0,        0, 0, 0, 0, 0, 1};
        vecs[8]  = '{0, 1, 1, 0, 32'h0,        1, 0, 1, 0, 0, 1};
        vecs[9]  = '{0, 0, 0, 1, 32'hCAFEF00D, 0, 0, 0, 0, 1, 1};
        vecs[10] = '{0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 1};

        reset = 1'b1;
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 32'hBFC00000;
        inst_wstrb = 4'h0; inst_wdata = 32'h0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 32'h0;
        data_wstrb = 4'h0; data_wdata = 32'h0;
        addr_ok = 0; data_ok = 0; rdata = 32'h0;
        @(posedge clk);
        #1;

        // Outputs held quiet in reset even with requests and slave handshakes active.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b1);
            begin_cycle();
            chk("reset_req", 32'(s_req[0]), 32'd0);
            chk("reset_data_ok", 32'(s_inst_data_ok[0] | s_data_data_ok[0]), 32'd0);
            chk("reset_proto_err", 32'(s_proto_err[0]), 32'd0);
            end_cycle();
        end
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].ireq, vecs[i].dreq, vecs[i].aok, vecs[i].dok);
            rdata = vecs[i].rd;
            begin_cycle();
            chk($sformatf("vec%0d_req", i), 32'(s_req[0]), 32'(vecs[i].e_req));
            chk($sformatf("vec%0d_inst_addr_ok", i), 32'(s_inst_addr_ok[0]), 32'(vecs[i].e_iaok));
            chk($sformatf("vec%0d_data_addr_ok", i), 32'(s_data_addr_ok[0]), 32'(vecs[i].e_daok));
            chk($sformatf("vec%0d_inst_data_ok", i), 32'(s_inst_data_ok[0]), 32'(vecs[i].e_idok));
            chk($sformatf("vec%0d_data_data_ok", i), 32'(s_data_data_ok[0]), 32'(vecs[i].e_ddok));
            chk($sformatf("vec%0d_proto_err", i), 32'(s_proto_err[0]), 32'(vecs[i].e_perr));
            if (vecs[i].e_idok) chk("vec_inst_rdata", s_inst_rdata[0], 32'h3C1DBFC0);
            end_cycle();
        end

        // Conflict with data priority: the store goes first, then the fetch.
        do_reset();
        data_wr = 1; data_addr = 32'h1FAF0000; data_wstrb = 4'hF; data_wdata = 32'h12345678;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        begin_cycle();
        chk("conf_addr", s_addr[0], 32'h1FAF0000);
        chk("conf_wr", 32'(s_wr[0]), 32'd1);
        chk("conf_wstrb", 32'(s_wstrb[0]), 32'hF);
        chk("conf_wdata", s_wdata[0], 32'h12345678);
        chk("conf_data_addr_ok", 32'(s_data_addr_ok[0]), 32'd1);
        chk("conf_inst_addr_ok", 32'(s_inst_addr_ok[0]), 32'd0);
        end_cycle();
        rdata = 32'h0;
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        begin_cycle();
        chk("conf_inst_second", 32'(s_inst_addr_ok[0]), 32'd1);
        chk("conf_inst_addr", s_addr[0], 32'hBFC00000);
        end_cycle();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        data_wr = 0;

        // Both masters requesting back to back: round-robin alternates starting with data.
        do_reset();
        for (int t = 0; t < 4; t++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            drive(1'b1, 1'b1, 1'b1, 1'b0);
            begin_cycle();
            obs = s_data_addr_ok[1];
            chk($sformatf("rr_order%0d", t), 32'(obs), (t % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("rr_granted%0d", t), 32'(s_inst_addr_ok[1] | s_data_addr_ok[1]), 32'd1);
            chk($sformatf("prio_order%0d", t), 32'(s_data_addr_ok[0]), 32'd1);
            end_cycle();
            step(1'b1, 1'b1, 1'b0, 1'b1);
        end

        // Grant lock: slave stalls inst for 5 cycles while data_req rises.
        do_reset();
        inst_addr = 32'hBFC00100; data_addr = 32'h00001000;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int t = 0; t < 5; t++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            begin_cycle();
            chk($sformatf("lock_addr%0d", t), s_addr[0], 32'hBFC00100);
            chk($sformatf("lock_req%0d", t), 32'(s_req[0]), 32'd1);
            end_cycle();
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        begin_cycle();
        chk("lock_inst_addr_ok", 32'(s_inst_addr_ok[0]), 32'd1);
        end_cycle();
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        begin_cycle();
        chk("lock_data_next", 32'(s_data_addr_ok[0]), 32'd1);
        end_cycle();
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset while waiting, then a late data_ok once out of reset.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        begin_cycle();
        chk("late_inst_data_ok", 32'(s_inst_data_ok[0]), 32'd0);
        chk("late_data_data_ok", 32'(s_data_data_ok[0]), 32'd0);
        end_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        begin_cycle();
        chk("late_proto_err", 32'(s_proto_err[0]), 32'd1);
        chk("late_idle_req", 32'(s_req[0]), 32'd0);
        end_cycle();

        // Random traffic against the model, including stray completions and resets.
        for (int t = 0; t < 400; t++) begin
            reset      = ($urandom_range(0, 63) == 0);
            inst_wr    = $urandom_range(0, 1) != 0;
            data_wr    = $urandom_range(0, 1) != 0;
            inst_size  = 2'($urandom_range(0, 2));
            data_size  = 2'($urandom_range(0, 2));
            inst_addr  = $urandom;
            data_addr  = $urandom;
            inst_wstrb = 4'($urandom);
            data_wstrb = 4'($urandom);
            inst_wdata = $urandom;
            data_wdata = $urandom;
            rdata      = $urandom;
            step($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 1) != 0, $urandom_range(0, 3) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
